// File: rtl/ahb_filter_pkg.sv
// ahb_filter_pkg: shared types and constants for the AHB address filter.
//   HTRANS_* / HRESP_*  AHB-lite encodings
//   region_t            one address window {base, limit, en}; fields are held
//                       at REG_AW bits so any ADDR_WIDTH up to 64 fits
//   state_t             error-response FSM states
//   owner_t             who answers the current data phase
package ahb_filter_pkg;

  localparam int REG_AW = 64;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef struct packed {
    logic [REG_AW-1:0] base;
    logic [REG_AW-1:0] limit;
    logic              en;
  } region_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DS, OWN_FLT} owner_t;

endpackage

// File: rtl/ahb_region_match.sv
// ahb_region_match: combinational permission check for one address phase.
//   regions  programmed window table
//   haddr    address-phase address
//   hsize    transfer size (bytes = 2^hsize)
//   allow    1 = address inside an enabled window and size-aligned
module ahb_region_match
  import ahb_filter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 4
) (
  input  region_t [NUM_REGIONS-1:0] regions,
  input  logic    [ADDR_WIDTH-1:0]  haddr,
  input  logic    [2:0]             hsize,
  output logic                      allow
);

  logic [REG_AW-1:0]      addr_x;
  logic [NUM_REGIONS-1:0] hit;
  logic [6:0]             amask;
  logic                   aligned;

  assign addr_x = REG_AW'(haddr);

  // Inclusive window; base > limit can never satisfy both compares.
  for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_rgn
    assign hit[r] = regions[r].en &&
                    (regions[r].base <= addr_x) && (addr_x <= regions[r].limit);
  end

  // Low hsize bits must be zero (hsize up to 7 -> 128-byte transfers).
  assign amask   = ~(7'h7F << hsize);
  assign aligned = ~|(haddr[6:0] & amask);

  assign allow = (|hit) && aligned;

endmodule

// File: rtl/ahb_addr_filter.sv
// ahb_addr_filter: AHB-lite address filter between a master and one slave.
//   hclk/hresetn          clock, async active-low reset
//   hsel..hwdata, hready  upstream request
//   hreadyout/hresp/hrdata  response to the master
//   m_*                   downstream request / response (m_hready = hreadyout)
//   cfg_*                 region-table write port
//   blk_cnt/addr/valid    blocked-transfer log
// Allowed transfers pass through combinationally. Blocked ones are replaced by
// IDLE downstream and answered locally with the two-cycle ERROR response.
module ahb_addr_filter
  import ahb_filter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_WIDTH   = 16,
  localparam int IDX_W      = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  m_hsel,
  output logic [1:0]            m_htrans,
  output logic [2:0]            m_hburst,
  output logic [2:0]            m_hsize,
  output logic                  m_hwrite,
  output logic [ADDR_WIDTH-1:0] m_haddr,
  output logic [DATA_WIDTH-1:0] m_hwdata,
  output logic                  m_hready,
  input  logic                  m_hreadyout,
  input  logic [1:0]            m_hresp,
  input  logic [DATA_WIDTH-1:0] m_hrdata,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_limit,
  input  logic                  cfg_en,
  output logic [CNT_WIDTH-1:0]  blk_cnt,
  output logic [ADDR_WIDTH-1:0] blk_addr,
  output logic                  blk_valid
);

  region_t [NUM_REGIONS-1:0] regions;
  state_t                    state;
  owner_t                    owner;
  logic                      ds_burst;   // current burst is owned by the slave
  logic                      f_ready;
  logic [1:0]                f_resp;
  logic                      allow, addr_ph, busy_in, fwd, blk, busy_fwd;

  ahb_region_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGIONS(NUM_REGIONS)
  ) u_match (
    .regions(regions),
    .haddr  (haddr),
    .hsize  (hsize),
    .allow  (allow)
  );

  assign addr_ph  = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign busy_in  = hsel && (htrans == HTRANS_BUSY);
  assign fwd      = addr_ph && allow;
  assign blk      = addr_ph && !allow;
  assign busy_fwd = busy_in && ds_burst;

  // Downstream request: only select/trans are gated, the rest follow upstream.
  assign m_hsel   = fwd || busy_fwd;
  assign m_htrans = fwd ? htrans : (busy_fwd ? HTRANS_BUSY : HTRANS_IDLE);
  assign m_hburst = hburst;
  assign m_hsize  = hsize;
  assign m_hwrite = hwrite;
  assign m_haddr  = haddr;
  assign m_hwdata = hwdata;

  // Response mux: slave owns its data phases, the FSM owns everything else.
  assign hreadyout = (owner == OWN_DS) ? m_hreadyout : f_ready;
  assign hresp     = (owner == OWN_DS) ? m_hresp     : f_resp;
  assign hrdata    = (owner == OWN_DS) ? m_hrdata    : '0;
  assign m_hready  = hreadyout;

  // Region table; a write lands at the edge, so that edge's sample sees the
  // old contents. Out-of-range indices match no r and are dropped.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      regions <= '0;
    end else begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if (cfg_we && cfg_idx == IDX_W'(r))
          regions[r] <= '{base: REG_AW'(cfg_base), limit: REG_AW'(cfg_limit), en: cfg_en};
      end
    end
  end

  // Data-phase owner and burst owner (BUSY keeps the burst owner).
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      owner    <= OWN_NONE;
      ds_burst <= 1'b0;
    end else if (hready) begin
      owner <= fwd ? OWN_DS : (blk ? OWN_FLT : OWN_NONE);
      if (addr_ph)      ds_burst <= allow;
      else if (!busy_in) ds_burst <= 1'b0;
    end
  end

  // Two-cycle ERROR response with registered outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      f_ready <= 1'b1;
      f_resp  <= HRESP_OKAY;
    end else begin
      case (state)
        ST_ERR1: begin
          state   <= ST_ERR2;
          f_ready <= 1'b1;
          f_resp  <= HRESP_ERROR;
        end
        default: begin  // ST_IDLE, ST_ERR2: ERR2 samples the next phase too
          if (blk) begin
            state   <= ST_ERR1;
            f_ready <= 1'b0;
            f_resp  <= HRESP_ERROR;
          end else begin
            state   <= ST_IDLE;
            f_ready <= 1'b1;
            f_resp  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Blocked-transfer log.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      blk_cnt   <= '0;
      blk_addr  <= '0;
      blk_valid <= 1'b0;
    end else if (blk) begin
      if (!(&blk_cnt)) blk_cnt <= blk_cnt + 1'b1;
      blk_addr  <= haddr;
      blk_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_addr_filter.sv
module tb_ahb_addr_filter;
  import ahb_filter_pkg::*;

  localparam logic [31:0] SLV_DATA = 32'hDA7A_0001;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite, hready, hreadyout;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        m_hsel, m_hwrite, m_hready, m_hreadyout;
  logic [1:0]  m_htrans, m_hresp;
  logic [2:0]  m_hburst, m_hsize;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic        cfg_we, cfg_en;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_base, cfg_limit;
  logic [15:0] blk_cnt;
  logic [31:0] blk_addr;
  logic        blk_valid;
  logic        hready_frc;
  logic        leak_arm;
  logic        leak_seen = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt;
  logic [31:0] exp_addr;

  always #5 hclk = ~hclk;
  assign hready = hready_frc | hreadyout;

  ahb_addr_filter dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .m_hsel(m_hsel), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hsize(m_hsize),
    .m_hwrite(m_hwrite), .m_haddr(m_haddr), .m_hwdata(m_hwdata), .m_hready(m_hready),
    .m_hreadyout(m_hreadyout), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_en(cfg_en), .blk_cnt(blk_cnt), .blk_addr(blk_addr), .blk_valid(blk_valid)
  );

  // Flags any downstream address phase to 0x2000 while armed.
  always @(posedge hclk)
    if (leak_arm && m_hsel && m_htrans[1] && m_hready && m_haddr == 32'h2000)
      leak_seen <= 1'b1;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  kind;   // 0 = not an address phase, 1 = forwarded, 2 = blocked
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge hclk); #1;
  endtask

  task automatic bus_idle;
    hsel = 1'b0; htrans = HTRANS_IDLE;
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic [2:0] sz,
                       input logic w, input logic [31:0] a);
    hsel = s; htrans = t; hsize = sz; hwrite = w; haddr = a;
  endtask

  task automatic cfg_wr(input logic [1:0] i, input logic [31:0] b, input logic [31:0] l,
                        input logic e);
    cfg_idx = i; cfg_base = b; cfg_limit = l; cfg_en = e; cfg_we = 1'b1;
    tick;
    cfg_we = 1'b0;
  endtask

  initial begin
    hresetn = 1'b0; hready_frc = 1'b0; leak_arm = 1'b0;
    bus_idle; hburst = 3'b000; hsize = 3'd2; hwrite = 1'b0; haddr = '0; hwdata = 32'h1234_5678;
    m_hreadyout = 1'b1; m_hresp = HRESP_OKAY; m_hrdata = SLV_DATA;
    cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_limit = '0; cfg_en = 1'b0;

    //               sel   trans          size  wr    addr          kind
    vecs[0]  = '{1'b1, HTRANS_NONSEQ, 3'd2, 1'b1, 32'h0000_1004, 2'd1};
    vecs[1]  = '{1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h0000_2000, 2'd2};
    vecs[2]  = '{1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h0000_1002, 2'd2};
    vecs[3]  = '{1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h0000_1FFC, 2'd1};
    vecs[4]  = '{1'b1, HTRANS_NONSEQ, 3'd0, 1'b0, 32'h0000_1FFF, 2'd1};
    vecs[5]  = '{1'b1, HTRANS_NONSEQ, 3'd1, 1'b0, 32'h0000_0FFE, 2'd2};
    vecs[6]  = '{1'b1, HTRANS_SEQ,    3'd2, 1'b0, 32'h0000_1000, 2'd1};
    vecs[7]  = '{1'b0, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h0000_1004, 2'd0};
    vecs[8]  = '{1'b1, HTRANS_IDLE,   3'd2, 1'b0, 32'h0000_1004, 2'd0};
    vecs[9]  = '{1'b1, HTRANS_NONSEQ, 3'd3, 1'b0, 32'h0000_1008, 2'd1};
    vecs[10] = '{1'b1, HTRANS_NONSEQ, 3'd3, 1'b0, 32'h0000_1004, 2'd2};
    vecs[11] = '{1'b1, HTRANS_NONSEQ, 3'd1, 1'b1, 32'h0000_1FFE, 2'd1};

    // Reset state
    tick; tick;
    @(negedge hclk);
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, HRESP_OKAY);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_m_htrans", m_htrans, HTRANS_IDLE);
    chk("rst_m_hsel", m_hsel, 1'b0);
    chk("rst_blk_cnt", blk_cnt, 16'h0);
    chk("rst_blk_addr", blk_addr, 32'h0);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_m_hready", m_hready, 1'b1);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    tick;

    cfg_wr(2'd0, 32'h1000, 32'h1FFF, 1'b1);
    leak_arm = 1'b1;
    exp_cnt = 0; exp_addr = '0;

    // Table-driven single transfers
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sel, vecs[i].trans, vecs[i].size, vecs[i].wr, vecs[i].addr);
      @(negedge hclk);
      chk($sformatf("v%0d_m_hsel", i), m_hsel, vecs[i].kind == 2'd1);
      chk($sformatf("v%0d_m_htrans", i), m_htrans,
          (vecs[i].kind == 2'd1) ? vecs[i].trans : HTRANS_IDLE);
      if (vecs[i].kind == 2'd1) begin
        chk($sformatf("v%0d_m_haddr", i), m_haddr, vecs[i].addr);
        chk($sformatf("v%0d_m_hwrite", i), m_hwrite, vecs[i].wr);
      end
      @(posedge hclk); #1;
      bus_idle;
      @(negedge hclk);
      if (vecs[i].kind == 2'd2) begin
        exp_cnt++; exp_addr = vecs[i].addr;
        chk($sformatf("v%0d_err1_rdy", i), hreadyout, 1'b0);
        chk($sformatf("v%0d_err1_resp", i), hresp, HRESP_ERROR);
        chk($sformatf("v%0d_err1_rdata", i), hrdata, 32'h0);
        tick;
        @(negedge hclk);
        chk($sformatf("v%0d_err2_rdy", i), hreadyout, 1'b1);
        chk($sformatf("v%0d_err2_resp", i), hresp, HRESP_ERROR);
      end else begin
        chk($sformatf("v%0d_dp_rdy", i), hreadyout, 1'b1);
        chk($sformatf("v%0d_dp_resp", i), hresp, HRESP_OKAY);
        if (vecs[i].kind == 2'd1 && !vecs[i].wr)
          chk($sformatf("v%0d_dp_rdata", i), hrdata, SLV_DATA);
      end
      tick;
      chk($sformatf("v%0d_blk_cnt", i), blk_cnt, 16'(exp_cnt));
      chk($sformatf("v%0d_blk_addr", i), blk_addr, exp_addr);
      chk($sformatf("v%0d_blk_valid", i), blk_valid, exp_cnt != 0);
    end

    // Downstream wait state passes through
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h1000);
    tick;
    bus_idle; m_hreadyout = 1'b0;
    @(negedge hclk);
    chk("ws_rdy_low", hreadyout, 1'b0);
    chk("ws_m_hready", m_hready, 1'b0);
    tick;
    m_hreadyout = 1'b1;
    @(negedge hclk);
    chk("ws_rdy_high", hreadyout, 1'b1);
    chk("ws_rdata", hrdata, SLV_DATA);
    tick;

    // BUSY forwarded inside a slave-owned burst, suppressed otherwise
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h1000);
    tick;
    drive(1'b1, HTRANS_BUSY, 3'd2, 1'b0, 32'h1004);
    @(negedge hclk);
    chk("busy_ds_trans", m_htrans, HTRANS_BUSY);
    chk("busy_ds_sel", m_hsel, 1'b1);
    tick;
    drive(1'b1, HTRANS_SEQ, 3'd2, 1'b0, 32'h1004);
    tick;
    bus_idle;
    tick;
    drive(1'b1, HTRANS_BUSY, 3'd2, 1'b0, 32'h1004);
    @(negedge hclk);
    chk("busy_none_trans", m_htrans, HTRANS_IDLE);
    chk("busy_none_sel", m_hsel, 1'b0);
    tick;
    bus_idle;
    tick;

    // INCR4 burst crossing the window end, cancelled in ERR2
    hburst = 3'b011;
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h1FF8);
    @(negedge hclk);
    chk("b0_trans", m_htrans, HTRANS_NONSEQ);
    tick;
    drive(1'b1, HTRANS_SEQ, 3'd2, 1'b0, 32'h1FFC);
    @(negedge hclk);
    chk("b1_trans", m_htrans, HTRANS_SEQ);
    chk("b1_addr", m_haddr, 32'h1FFC);
    tick;
    drive(1'b1, HTRANS_SEQ, 3'd2, 1'b0, 32'h2000);
    @(negedge hclk);
    chk("b2_trans", m_htrans, HTRANS_IDLE);
    chk("b2_sel", m_hsel, 1'b0);
    tick;
    drive(1'b1, HTRANS_SEQ, 3'd2, 1'b0, 32'h2004);
    @(negedge hclk);
    chk("b_err1_rdy", hreadyout, 1'b0);
    chk("b_err1_resp", hresp, HRESP_ERROR);
    chk("b_err1_trans", m_htrans, HTRANS_IDLE);
    tick;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    chk("b_err2_rdy", hreadyout, 1'b1);
    chk("b_err2_resp", hresp, HRESP_ERROR);
    chk("b_err2_trans", m_htrans, HTRANS_IDLE);
    tick;
    @(negedge hclk);
    chk("b_after_resp", hresp, HRESP_OKAY);
    chk("b_blk_cnt", blk_cnt, 16'(exp_cnt + 1));
    chk("b_blk_addr", blk_addr, 32'h2000);
    chk("no_leak_2000", leak_seen, 1'b0);
    bus_idle; hburst = 3'b000; leak_arm = 1'b0;
    tick;

    // Config write on the same edge as the address phase
    cfg_idx = 2'd1; cfg_base = 32'h2000; cfg_limit = 32'h2FFF; cfg_en = 1'b1; cfg_we = 1'b1;
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h2000);
    @(negedge hclk);
    chk("cfg_old_trans", m_htrans, HTRANS_IDLE);
    tick;
    cfg_we = 1'b0; bus_idle;
    @(negedge hclk);
    chk("cfg_old_err", hresp, HRESP_ERROR);
    tick; tick;
    chk("cfg_blk_cnt", blk_cnt, 16'(exp_cnt + 2));
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h2000);
    @(negedge hclk);
    chk("cfg_new_trans", m_htrans, HTRANS_NONSEQ);
    chk("cfg_new_sel", m_hsel, 1'b1);
    tick;
    bus_idle;
    @(negedge hclk);
    chk("cfg_new_resp", hresp, HRESP_OKAY);
    chk("cfg_new_rdata", hrdata, SLV_DATA);
    tick;

    // Asynchronous reset in the middle of ERR1
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h3000);
    tick;
    bus_idle;
    chk("ar_pre_rdy", hreadyout, 1'b0);
    #2 hresetn = 1'b0;
    #1;
    chk("ar_rdy", hreadyout, 1'b1);
    chk("ar_resp", hresp, HRESP_OKAY);
    chk("ar_blk_cnt", blk_cnt, 16'h0);
    chk("ar_blk_valid", blk_valid, 1'b0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    tick;
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h1004);
    @(negedge hclk);
    chk("ar_tbl_clear_trans", m_htrans, HTRANS_IDLE);
    tick;
    bus_idle;
    @(negedge hclk);
    chk("ar_tbl_clear_err", hresp, HRESP_ERROR);
    tick; tick;
    chk("ar_blk_cnt1", blk_cnt, 16'h1);

    // Counter saturation: hready held high so every cycle is a blocked sample
    hready_frc = 1'b1;
    drive(1'b1, HTRANS_NONSEQ, 3'd2, 1'b0, 32'h1004);
    repeat (65534) @(posedge hclk);
    #1;
    chk("sat_cnt_full", blk_cnt, 16'hFFFF);
    tick;
    chk("sat_cnt_hold", blk_cnt, 16'hFFFF);
    chk("sat_addr", blk_addr, 32'h1004);
    bus_idle; hready_frc = 1'b0;
    tick; tick; tick;
    @(negedge hclk);
    chk("sat_end_resp", hresp, HRESP_OKAY);
    chk("sat_end_rdy", hreadyout, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
